// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared types and default widths for the cpu_seq run controller.
//   seq_state_t : controller state encoding (IDLE=0, LOAD=1, RUN=2, HALT=3)
//   DW_DEF      : default instruction/data word width
//   PW_DEF      : default program counter / ROM address width
//   CW_DEF      : default run cycle counter width
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } seq_state_t;

    localparam int DW_DEF = 16;
    localparam int PW_DEF = 15;
    localparam int CW_DEF = 32;

endpackage

// File: rtl/cpu_halt_det.sv
// cpu_halt_det: detects the terminal jump loop of a running Hack program.
// Keeps the last two program counter values. Once two run cycles of history
// exist, a cycle whose pc equals the pc of two cycles earlier is a loop match
// (covers both the 2-cycle "@n; 0;JMP" loop and a 1-cycle self loop).
// HALT_CNT consecutive matches raise halt on the last matching cycle.
// Ports:
//   clk50m : system clock, rising edge
//   rst    : asynchronous active-high reset
//   clr    : clears warm-up and match counters (run entry)
//   en     : cpu is running this cycle; history advances
//   pc     : cpu program counter
//   halt   : combinational halt decision for this cycle
module cpu_halt_det #(
    parameter int PW       = 15,
    parameter int HALT_CNT = 8
) (
    input  logic          clk50m,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] pc,
    output logic          halt
);

    localparam int HCW = $clog2(HALT_CNT + 1);
    localparam logic [HCW-1:0] LAST_MATCH = HCW'(HALT_CNT - 1);

    logic [PW-1:0]  pc_d1_q, pc_d1_d;
    logic [PW-1:0]  pc_d2_q, pc_d2_d;
    logic [1:0]     warm_q, warm_d;
    logic [HCW-1:0] cnt_q, cnt_d;
    logic           match;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pc_d1_d = pc_d1_q;
        pc_d2_d = pc_d2_q;
        warm_d  = warm_q;
        cnt_d   = cnt_q;
        match   = en && (warm_q == 2'd2) && (pc == pc_d2_q);
        halt    = match && (cnt_q == LAST_MATCH);
        if (clr) begin
            warm_d = '0;
            cnt_d  = '0;
        end else if (en) begin
            pc_d1_d = pc;
            pc_d2_d = pc_d1_q;
            if (warm_q != 2'd2) warm_d = warm_q + 2'd1;
            cnt_d = match ? cnt_q + HCW'(1) : '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            pc_d1_q <= '0;
            pc_d2_q <= '0;
            warm_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pc_d1_q <= pc_d1_d;
            pc_d2_q <= pc_d2_d;
            warm_q  <= warm_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: run controller for a Hack-style cpu core and its instruction ROM.
// Streams a program image into the ROM write port, releases the cpu from
// reset, counts run cycles and parks the cpu in reset once the terminal jump
// loop is seen (or on abort).
// Optional feature macro: CPU_SEQ_WDOG_EN adds a run-cycle watchdog
// (ports wdog_limit, timeout).
// Ports:
//   clk50m, rst              : clock, asynchronous active-high reset
//   start, reload, abort     : host control
//   ld_valid/ld_data/ld_last : image stream in, ld_ready back-pressure out
//   rom_we/rom_addr/rom_wdata: ROM write port
//   cpu_rst_n                : cpu reset, active-low, high only in RUN
//   pc                       : cpu program counter
//   state, halted, cycles    : status readout
//   wdog_limit, timeout      : watchdog (CPU_SEQ_WDOG_EN only)
module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int PW       = PW_DEF,
    parameter int HALT_CNT = 8,
    parameter int CW       = CW_DEF
) (
    input  logic          clk50m,
    input  logic          rst,
    input  logic          start,
    input  logic          reload,
    input  logic          abort,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          rom_we,
    output logic [PW-1:0] rom_addr,
    output logic [DW-1:0] rom_wdata,
    output logic          cpu_rst_n,
    input  logic [PW-1:0] pc,
    output logic [1:0]    state,
    output logic          halted,
    output logic [CW-1:0] cycles
`ifdef CPU_SEQ_WDOG_EN
    ,
    input  logic [CW-1:0] wdog_limit,
    output logic          timeout
`endif
);

    seq_state_t    state_q, state_d;
    logic [PW-1:0] ld_addr_q, ld_addr_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          enter_run;
    logic          wd_fire;
    logic          det_halt;

`ifdef CPU_SEQ_WDOG_EN
    logic          timeout_q, timeout_d;
`endif

    assign cpu_rst_n = (state_q == S_RUN);
    assign halted    = (state_q == S_HALT);
    assign ld_ready  = (state_q == S_LOAD);
    assign rom_we    = ld_valid & ld_ready;
    assign rom_addr  = ld_addr_q;
    assign rom_wdata = ld_data;
    assign state     = state_q;
    assign cycles    = cycles_q;

    cpu_halt_det #(
        .PW       (PW),
        .HALT_CNT (HALT_CNT)
    ) u_halt_det (
        .clk50m (clk50m),
        .rst    (rst),
        .clr    (enter_run),
        .en     (state_q == S_RUN),
        .pc     (pc),
        .halt   (det_halt)
    );

    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        cycles_d  = cycles_q;
        enter_run = 1'b0;
        wd_fire   = 1'b0;
`ifdef CPU_SEQ_WDOG_EN
        timeout_d = timeout_q;
        wd_fire   = (state_q == S_RUN) && (wdog_limit != '0) && (cycles_q == wdog_limit);
`endif
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
`ifdef CPU_SEQ_WDOG_EN
                    timeout_d = 1'b0;
`endif
                    if (reload) begin
                        state_d   = S_LOAD;
                        ld_addr_d = '0;
                    end else begin
                        enter_run = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // The address wraps to 0 naturally after the last ROM word.
                if (rom_we) ld_addr_d = ld_addr_q + PW'(1);
                if (abort) state_d = S_HALT;
                else if (rom_we && (ld_last || ld_addr_q == '1)) enter_run = 1'b1;
            end
            S_RUN: begin
                // On a watchdog expiry cycles already equals the limit; hold it.
                if (!wd_fire && cycles_q != '1) cycles_d = cycles_q + CW'(1);
                if (abort) begin
                    state_d = S_HALT;
                end else if (wd_fire) begin
                    state_d = S_HALT;
`ifdef CPU_SEQ_WDOG_EN
                    timeout_d = 1'b1;
`endif
                end else if (det_halt) begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (enter_run) begin
            state_d  = S_RUN;
            cycles_d = '0;
        end
    end

    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ld_addr_q <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            cycles_q  <= cycles_d;
        end
    end

`ifdef CPU_SEQ_WDOG_EN
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= timeout_d;
    end
    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: self-checking bench for cpu_seq (small ROM and counter widths
// so the full-ROM wrap and cycle saturation are reachable). A behavioural
// model, updated on every falling edge from the inputs about to be sampled,
// is compared against all outputs each cycle; directed sequences add literal
// expectations, followed by a randomized phase.
// Optional feature macro: CPU_SEQ_WDOG_EN enables the watchdog checks.
module tb_cpu_seq;
    import cpu_seq_pkg::*;

    localparam int DW       = 16;
    localparam int PW       = 5;
    localparam int HALT_CNT = 8;
    localparam int CW       = 8;
    localparam int ROM_WORDS = 1 << PW;
    localparam int CMAX      = (1 << CW) - 1;

    logic          clk50m = 1'b0;
    logic          rst, start, reload, abort, ld_valid, ld_last;
    logic [DW-1:0] ld_data;
    logic          ld_ready, rom_we, cpu_rst_n, halted;
    logic [PW-1:0] rom_addr, pc;
    logic [DW-1:0] rom_wdata;
    logic [1:0]    state;
    logic [CW-1:0] cycles;
`ifdef CPU_SEQ_WDOG_EN
    logic [CW-1:0] wdog_limit;
    logic          timeout;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    always #10 clk50m = ~clk50m;

    cpu_seq #(.DW(DW), .PW(PW), .HALT_CNT(HALT_CNT), .CW(CW)) dut (
        .clk50m    (clk50m),
        .rst       (rst),
        .start     (start),
        .reload    (reload),
        .abort     (abort),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_rst_n (cpu_rst_n),
        .pc        (pc),
        .state     (state),
        .halted    (halted),
        .cycles    (cycles)
`ifdef CPU_SEQ_WDOG_EN
        ,
        .wdog_limit (wdog_limit),
        .timeout    (timeout)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ROM writes observed on the falling edge (the value the next rise commits).
    logic [PW-1:0] cap_addr[$];
    logic [DW-1:0] cap_data[$];
    always @(negedge clk50m) begin
        if (rom_we) begin
            cap_addr.push_back(rom_addr);
            cap_data.push_back(rom_wdata);
        end
    end

    // ---------------- behavioural model ----------------
    seq_state_t m_state;
    int         m_addr, m_cycles, m_run;
    int         m_hist[$];
    bit         m_tmo;

    task automatic model_reset();
        m_state  = S_IDLE;
        m_addr   = 0;
        m_cycles = 0;
        m_run    = 0;
        m_tmo    = 0;
        m_hist.delete();
    endtask

    task automatic model_enter_run();
        m_state  = S_RUN;
        m_cycles = 0;
        m_run    = 0;
        m_hist.delete();
    endtask

    task automatic model_step();
        bit wd, hit;
        wd  = 0;
        hit = 0;
        case (m_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    m_tmo = 0;
                    if (reload) begin
                        m_state = S_LOAD;
                        m_addr  = 0;
                    end else begin
                        model_enter_run();
                    end
                end
            end
            S_LOAD: begin
                bit done;
                done = 0;
                if (ld_valid) begin
                    done   = ld_last || (m_addr == ROM_WORDS - 1);
                    m_addr = (m_addr + 1) % ROM_WORDS;
                end
                if (abort) m_state = S_HALT;
                else if (done) model_enter_run();
            end
            default: begin
`ifdef CPU_SEQ_WDOG_EN
                wd = (wdog_limit != 0) && (m_cycles == int'(wdog_limit));
`endif
                if (m_hist.size() >= 2 && int'(pc) == m_hist[m_hist.size() - 2]) begin
                    hit = (m_run == HALT_CNT - 1);
                    m_run++;
                end else begin
                    m_run = 0;
                end
                m_hist.push_back(int'(pc));
                if (m_hist.size() > 2) void'(m_hist.pop_front());
                if (!wd && m_cycles < CMAX) m_cycles++;
                if (abort) m_state = S_HALT;
                else if (wd) begin
                    m_state = S_HALT;
                    m_tmo   = 1;
                end else if (hit) m_state = S_HALT;
            end
        endcase
    endtask

    // Single compare process: check outputs, then advance the model with the
    // inputs that the coming rising edge will sample.
    initial begin
        model_reset();
        forever begin
            @(negedge clk50m);
            if (rst) model_reset();
            check("m_state", state, m_state);
            check("m_halted", halted, m_state == S_HALT);
            check("m_cpu_rst_n", cpu_rst_n, m_state == S_RUN);
            check("m_ld_ready", ld_ready, m_state == S_LOAD);
            check("m_rom_we", rom_we, (m_state == S_LOAD) && ld_valid);
            check("m_cycles", cycles, m_cycles);
            if ((m_state == S_LOAD) && ld_valid) begin
                check("m_rom_addr", rom_addr, m_addr);
                check("m_rom_wdata", rom_wdata, ld_data);
            end
`ifdef CPU_SEQ_WDOG_EN
            check("m_timeout", timeout, m_tmo);
`endif
            if (!rst) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk50m);
        #1;
    endtask

    task automatic idle_inputs();
        start    = 0;
        reload   = 0;
        abort    = 0;
        ld_valid = 0;
        ld_last  = 0;
    endtask

    // Non-halting pc stream: pc never equals the pc two cycles earlier.
    function automatic logic [PW-1:0] walk_pc(input int k);
        return PW'(k % 5);
    endfunction

    initial begin
        logic [DW-1:0] img[4];
        logic [DW-1:0] gap_data[4];
        int            k;
        img[0] = 16'h0003; img[1] = 16'hE308; img[2] = 16'h0002; img[3] = 16'hEA87;
        rst = 1;
        pc = '0;
        ld_data = '0;
        idle_inputs();
`ifdef CPU_SEQ_WDOG_EN
        wdog_limit = '0;
`endif
        repeat (3) step();
        check("rst_state", state, 0);
        check("rst_cycles", cycles, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_ld_ready", ld_ready, 0);
        rst = 0;
        step();

        // Load the 4-word image.
        start = 1; reload = 1;
        step();
        idle_inputs();
        check("load_state", state, 1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_data = img[i]; ld_last = (i == 3);
            step();
        end
        idle_inputs();
        check("run_after_last", state, 2);
        check("cpu_rst_n_run", cpu_rst_n, 1);
        check("load_count", cap_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("load_addr", cap_addr[i], i);
            check("load_data", cap_data[i], img[i]);
        end

        // Halt on 0,1,2,3,2,3,... : 8 matches starting at the 5th cycle.
        k = 0;
        while (!halted && k < 40) begin
            pc = (k < 4) ? PW'(k) : PW'(2 + (k % 2));
            step();
            k++;
        end
        check("halt_steps", k, 12);
        check("halt_cycles", cycles, 12);
        repeat (3) step();
        check("cycles_frozen", cycles, 12);
        check("halt_cpu_rst_n", cpu_rst_n, 0);

        // Rerun; start/reload and ld_valid in RUN are ignored.
        start = 1; reload = 0;
        step();
        check("rerun_state", state, 2);
        start = 1; reload = 1; ld_valid = 1; pc = walk_pc(0);
        step();
        idle_inputs();
        for (int i = 1; i < 20; i++) begin
            pc = walk_pc(i);
            step();
        end
        abort = 1;
        step();
        idle_inputs();
        check("abort_run_state", state, 3);
        check("abort_run_cycles", cycles, 21);
        check("no_we_in_run", cap_addr.size(), 4);

        // Gapped load with abort on the accepted last word.
        start = 1; reload = 1;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            gap_data[i] = DW'($urandom);
            ld_valid = (i == 0 || i == 3);
            ld_data  = gap_data[i];
            ld_last  = (i == 3);
            abort    = (i == 3);
            step();
            if (i == 1) check("gap_addr", rom_addr, 1);
        end
        idle_inputs();
        check("abort_load_state", state, 3);
        check("abort_load_rst_n", cpu_rst_n, 0);
        check("abort_load_cycles", cycles, 21);
        check("gap_count", cap_addr.size(), 6);
        check("gap_addr0", cap_addr[4], 0);
        check("gap_addr1", cap_addr[5], 1);
        check("gap_data1", cap_data[5], gap_data[3]);

        // Full-ROM load without ld_last: exits to RUN, address wraps to 0.
        start = 1; reload = 1;
        step();
        idle_inputs();
        for (int i = 0; i < ROM_WORDS; i++) begin
            ld_valid = 1; ld_data = DW'(i + 16'h100);
            step();
        end
        idle_inputs();
        check("full_state", state, 2);
        check("full_wrap_addr", rom_addr, 0);
        check("full_last_addr", cap_addr[cap_addr.size() - 1], ROM_WORDS - 1);
        abort = 1;
        step();
        idle_inputs();

        // 1-cycle self loop: constant pc halts after 2 + HALT_CNT cycles.
        start = 1; reload = 0;
        step();
        idle_inputs();
        pc = 5'd9;
        k = 0;
        while (!halted && k < 40) begin
            step();
            k++;
        end
        check("self_loop_steps", k, 10);
        check("self_loop_cycles", cycles, 10);

        // Cycle counter saturation.
        start = 1; reload = 0;
        step();
        idle_inputs();
        for (int i = 0; i < 300; i++) begin
            pc = walk_pc(i);
            step();
        end
        check("sat_cycles", cycles, CMAX);
        abort = 1;
        step();
        idle_inputs();
        check("sat_hold", cycles, CMAX);

        // Asynchronous reset mid-RUN.
        start = 1; reload = 0;
        step();
        idle_inputs();
        for (int i = 0; i < 50; i++) begin
            pc = walk_pc(i);
            step();
        end
        check("pre_rst_cycles", cycles, 50);
        rst = 1;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_cycles", cycles, 0);
        check("async_rst_n", cpu_rst_n, 0);
        step();
        rst = 0;
        step();

`ifdef CPU_SEQ_WDOG_EN
        wdog_limit = 8'd100;
        start = 1; reload = 0;
        step();
        idle_inputs();
        k = 0;
        while (!halted && k < 200) begin
            pc = walk_pc(k);
            step();
            k++;
        end
        check("wdog_steps", k, 101);
        check("wdog_timeout", timeout, 1);
        check("wdog_cycles", cycles, 100);
        start = 1; reload = 0;
        step();
        idle_inputs();
        check("wdog_clear", timeout, 0);
        abort = 1;
        step();
        idle_inputs();
        wdog_limit = '0;
`endif

        // Randomized phase.
        begin
            int loop_left;
            loop_left = 0;
            for (int i = 0; i < 3000; i++) begin
                start    = ($urandom_range(0, 15) == 0);
                reload   = $urandom_range(0, 1) != 0;
                abort    = ($urandom_range(0, 63) == 0);
                ld_valid = $urandom_range(0, 1) != 0;
                ld_data  = DW'($urandom);
                ld_last  = ($urandom_range(0, 7) == 0);
                rst      = ($urandom_range(0, 499) == 0);
                if (loop_left == 0 && $urandom_range(0, 39) == 0) loop_left = 30;
                if (loop_left > 0) begin
                    pc = PW'(20 + (i % 2));
                    loop_left--;
                end else begin
                    pc = PW'($urandom_range(0, 3));
                end
`ifdef CPU_SEQ_WDOG_EN
                wdog_limit = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(1, 40)) : '0;
`endif
                step();
            end
            rst = 0;
            idle_inputs();
            repeat (3) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL sim_timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
